alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = in reset).
REQ-004 The block SHALL have port start, input, 1 bit, request to execute one operation.
REQ-005 The block SHALL have port Operation, input, 4 bits, the ALU operation code from the ALU controller.
REQ-006 The block SHALL have port SrcA, input, DATA_WIDTH bits, first operand.
REQ-007 The block SHALL have port SrcB, input, DATA_WIDTH bits, second operand or shift amount.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a shift is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port ALUResult, output, DATA_WIDTH bits, registered result.
REQ-011 The block SHALL have port Zero, output, 1 bit, registered branch-condition flag.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-013 start SHALL be accepted on a rising edge only when state is IDLE or DONE; on acceptance Operation, SrcA and SrcB are latched internally.
REQ-014 start in SHIFT SHALL be ignored, with no queuing; input changes in SHIFT SHALL NOT affect the result.
REQ-015 Codes SHALL decode as: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 1001 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1100 SLT/BLT (signed), 1010 LUI (result = SrcB), 1000 BEQ, 1101 BNE, 1110 BGE (signed).
REQ-016 Non-shift codes SHALL complete with latency 1: state goes to DONE on the accept edge, so done is high in the following cycle.
REQ-017 Shift codes SHALL use shamt = SrcB[4:0] and shift the latched operand one bit per cycle; no barrel shifter is permitted.
REQ-018 For a shift with shamt = 0, the block SHALL go directly to DONE with ALUResult = SrcA, latency 1.
REQ-019 For a shift with shamt > 0, the block SHALL enter SHIFT with count = shamt, perform one shift and decrement count per edge, and enter DONE on the edge performing the last shift, giving latency = 1 + shamt.
REQ-020 SRL SHALL fill with 0, SRA SHALL fill with the latched SrcA MSB, and SLL SHALL fill the LSB with 0.
REQ-021 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH; no overflow flag exists.
REQ-022 Code 1100 SHALL give ALUResult = {0..., A<B signed} and Zero = (A<B signed).
REQ-023 Codes 1000, 1101 and 1110 SHALL give ALUResult = 0 and Zero = (A==B), (A!=B) and (A>=B signed) respectively.
REQ-024 All codes other than 1000, 1100, 1101 and 1110 SHALL give Zero = 0.
REQ-025 Undefined codes SHALL give ALUResult = 0 and Zero = 0 with latency 1.
REQ-026 ALUResult and Zero SHALL update only on the edge entering DONE and hold until the next completion.
REQ-027 start in DONE SHALL be accepted in that same cycle, giving back-to-back operations: DONE is followed by DONE or SHIFT, with no IDLE gap.
REQ-028 DONE with no start SHALL return to IDLE on the next edge.

Reset
REQ-029 While reset = 0, the block SHALL force state to IDLE, busy = 0, done = 0, ALUResult = 0, Zero = 0 and the shift count to 0, asynchronously.
REQ-030 Reset asserted during SHIFT SHALL abandon the operation; no done pulse follows deassertion.
REQ-031 The first start SHALL be accepted on the first rising edge with reset = 1.

Verification
REQ-032 ADD: Operation=0010, A=0xFFFFFFFF, B=2 -> next cycle done=1, ALUResult=0x00000001, Zero=0, busy never high.
REQ-033 SRA: Operation=0111, A=0x80000000, B=4 -> busy high 4 cycles, done in cycle 5, ALUResult=0xF8000000; a start issued during busy is ignored.
REQ-034 Branch: BGE with A=-3, B=-3 -> Zero=1, ALUResult=0; BLT with A=-1, B=1 -> Zero=1, ALUResult=1; BNE with A=5, B=5 -> Zero=0.
REQ-035 Back-to-back: SLL with A=1, B=31 followed by start for SUB (A=5, B=7) in the DONE cycle -> ALUResult=0x80000000, then 0xFFFFFFFE exactly one cycle later.
REQ-036 Reset mid-SRL: A=0xF0, B=8, reset low after 3 shift cycles -> all outputs 0 immediately; no done after release; the next ADD completes normally.
REQ-037 Edge cases: SLL with B=0x20 (shamt 0) -> latency 1, ALUResult=A; Operation=1111 -> ALUResult=0, Zero=0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle logic/arithmetic/compare ops, and shifts that
// move the latched operand one bit per clock under a shift-amount down-counter.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | shifting latched operand, one bit per cycle
// DONE  | ALUResult/Zero valid for one cycle; start accepted here too
module alu_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_BGE = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              op_q;
  logic [DATA_WIDTH-1:0]   sh_q;
  logic [4:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;

  logic [DATA_WIDTH-1:0]   alu_res_d;
  logic                    alu_zero_d;
  logic [DATA_WIDTH-1:0]   sh_d;
  logic [4:0]              shamt;
  logic                    is_shift;
  logic                    lt_signed;
  logic                    accept;

  assign shamt     = SrcB[4:0];
  assign is_shift  = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign lt_signed = $signed(SrcA) < $signed(SrcB);
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Shift codes yield SrcA here, which is the zero-shift-amount result.
  always_comb begin
    alu_res_d  = '0;
    alu_zero_d = 1'b0;
    case (Operation)
      OP_AND: alu_res_d = SrcA & SrcB;
      OP_OR:  alu_res_d = SrcA | SrcB;
      OP_ADD: alu_res_d = SrcA + SrcB;
      OP_SUB: alu_res_d = SrcA - SrcB;
      OP_XOR: alu_res_d = SrcA ^ SrcB;
      OP_LUI: alu_res_d = SrcB;
      OP_SLL, OP_SRL, OP_SRA: alu_res_d = SrcA;
      OP_SLT: begin
        alu_res_d  = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
        alu_zero_d = lt_signed;
      end
      OP_BEQ: alu_zero_d = (SrcA == SrcB);
      OP_BNE: alu_zero_d = (SrcA != SrcB);
      OP_BGE: alu_zero_d = !lt_signed;
      default: begin
        alu_res_d  = '0;
        alu_zero_d = 1'b0;
      end
    endcase
  end

  // Single-bit step only; SRA replicates the operand MSB, which is the latched SrcA sign.
  always_comb begin
    sh_d = sh_q;
    case (op_q)
      OP_SLL:  sh_d = {sh_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  sh_d = {1'b0, sh_q[DATA_WIDTH-1:1]};
      OP_SRA:  sh_d = {sh_q[DATA_WIDTH-1], sh_q[DATA_WIDTH-1:1]};
      default: sh_d = sh_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_shift && (shamt != 5'd0)) begin
              state_q <= ST_SHIFT;
              op_q    <= Operation;
              sh_q    <= SrcA;
              cnt_q   <= shamt;
            end else begin
              state_q  <= ST_DONE;
              result_q <= alu_res_d;
              zero_q   <= alu_zero_d;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q  <= ST_DONE;
            result_q <= sh_d;
            zero_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results with due cycles,
// a negedge monitor pops and compares whenever done is high.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         busy;
  logic         done;
  logic [W-1:0] ALUResult;
  logic         Zero;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    int           due;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           errs = 0;
  int           checks = 0;
  logic [W-1:0] last_res = '0;
  logic         last_z = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the operation table.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = '0;
    z   = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a - b;
      4'b1001: r = a ^ b;
      4'b0100: begin r = a << sh; lat = 1 + sh; end
      4'b0101: begin r = a >> sh; lat = 1 + sh; end
      4'b0111: begin r = W'($signed(a) >>> sh); lat = 1 + sh; end
      4'b1100: begin z = ($signed(a) < $signed(b)); r = {{(W-1){1'b0}}, z}; end
      4'b1010: r = b;
      4'b1000: z = (a == b);
      4'b1101: z = (a != b);
      4'b1110: z = ($signed(a) >= $signed(b));
      default: begin r = '0; z = 1'b0; end
    endcase
  endfunction

  // Entered at a negedge with the DUT in IDLE or DONE; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit junk, input string tag);
    logic [W-1:0] r;
    logic         z;
    int           lat;
    exp_t         e;
    model(op, a, b, r, z, lat);
    start = 1'b1; Operation = op; SrcA = a; SrcB = b;
    e.res = r; e.z = z; e.due = cyc + lat; e.name = tag;
    sb.push_back(e);
    @(negedge clk);
    for (int k = 1; k < lat; k++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " hold"}, 64'(ALUResult), 64'(last_res));
      start     = junk ? 1'($urandom_range(1, 0)) : 1'b0;
      Operation = 4'($urandom);
      SrcA      = $urandom;
      SrcB      = $urandom;
      @(negedge clk);
    end
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    start    = 1'b0;
    last_res = r;
    last_z   = z;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1 result 0x%0h expected no done (cycle %0d)", ALUResult, cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, " result"}, 64'(ALUResult), 64'(e.res));
        check({e.name, " zero"}, 64'(Zero), 64'(e.z));
        check({e.name, " latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset = 1'b0; start = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst result", 64'(ALUResult), 64'd0);
    check("rst zero", 64'(Zero), 64'd0);
    reset = 1'b1;

    run_op(4'b0010, 32'hFFFF_FFFF, 32'd2, 1'b0, "add_wrap");
    run_op(4'b0111, 32'h8000_0000, 32'd4, 1'b1, "sra4");
    run_op(4'b1110, -32'sd3, -32'sd3, 1'b0, "bge_eq");
    run_op(4'b1100, -32'sd1, 32'd1, 1'b0, "blt");
    run_op(4'b1101, 32'd5, 32'd5, 1'b0, "bne_eq");
    run_op(4'b1000, 32'd9, 32'd9, 1'b0, "beq_eq");
    run_op(4'b0100, 32'd1, 32'd31, 1'b1, "sll31");
    run_op(4'b0011, 32'd5, 32'd7, 1'b0, "sub_b2b");
    run_op(4'b0100, 32'h1234_5678, 32'h20, 1'b0, "sll_sh0");
    run_op(4'b1111, 32'hDEAD_BEEF, 32'h1, 1'b0, "undef");
    run_op(4'b1010, 32'h1, 32'hABCD_E000, 1'b0, "lui");
    run_op(4'b0101, 32'h8000_0001, 32'd3, 1'b1, "srl3");
    @(negedge clk);

    // Abandon an SRL with reset after three shift cycles.
    start = 1'b1; Operation = 4'b0101; SrcA = 32'hF0; SrcB = 32'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst result", 64'(ALUResult), 64'd0);
    check("midrst zero", 64'(Zero), 64'd0);
    last_res = '0;
    last_z   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    run_op(4'b0010, 32'd100, 32'd23, 1'b0, "add_after_rst");

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(15, 0));
      a  = $urandom;
      b  = ($urandom_range(7, 0) == 0) ? (a & 32'hFFFF_FFE0) : $urandom;
      if ($urandom_range(3, 0) == 0) b = a;
      run_op(op, a, b, 1'b1, $sformatf("rnd%0d_op%0h", i, op));
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(2, 1)) @(negedge clk);
    end

    start = 1'b0;
    repeat (40) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
